// File: rtl/mult_div_unit.sv
// Iterative signed 32-bit Booth multiplier / restoring divider.
// The divider is built only when MULT_DIV_DIVIDER_EN is defined.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        mult_start,
  input  logic        div_start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] mult_hi,
  output logic [31:0] mult_lo,
  output logic [31:0] div_hi,
  output logic [31:0] div_lo,
  output logic        div_zero,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE, MULT, DIV, FIX, DONE
  } state_t;

  state_t      state, stateNext;
  logic [4:0]  cnt;
  logic [31:0] opReg;
  logic [31:0] pHi, pLo;
  logic        qm1;
  logic [32:0] boothSum;
  logic        lastIter;

  assign lastIter = (cnt == 5'd31);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

`ifdef MULT_DIV_DIVIDER_EN
  logic        negQ, negR;
  logic [31:0] divHiR, divLoR;
  logic [31:0] absA, absB;
  logic [33:0] divDiff;

  assign absA    = a[31] ? -a : a;
  assign absB    = b[31] ? -b : b;
  assign divDiff = {1'b0, pHi, pLo[31]} - {2'b00, opReg};
  assign div_hi  = divHiR;
  assign div_lo  = divLoR;
`else
  assign div_hi  = '0;
  assign div_lo  = '0;
`endif

  always_comb begin
    boothSum = {pHi[31], pHi};
    unique case ({pLo[0], qm1})
      2'b01:   boothSum = {pHi[31], pHi} + {opReg[31], opReg};
      2'b10:   boothSum = {pHi[31], pHi} - {opReg[31], opReg};
      default: boothSum = {pHi[31], pHi};
    endcase
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (mult_start)
          stateNext = MULT;
        else if (div_start) begin
`ifdef MULT_DIV_DIVIDER_EN
          stateNext = (b == '0) ? DONE : DIV;
`else
          stateNext = DONE;
`endif
        end
      end
      MULT: if (lastIter) stateNext = DONE;
`ifdef MULT_DIV_DIVIDER_EN
      DIV:  if (lastIter) stateNext = FIX;
      FIX:  stateNext = DONE;
`endif
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      opReg    <= '0;
      pHi      <= '0;
      pLo      <= '0;
      qm1      <= 1'b0;
      mult_hi  <= '0;
      mult_lo  <= '0;
      div_zero <= 1'b0;
`ifdef MULT_DIV_DIVIDER_EN
      negQ     <= 1'b0;
      negR     <= 1'b0;
      divHiR   <= '0;
      divLoR   <= '0;
`endif
    end else begin
      state <= stateNext;
      unique case (state)
        IDLE: begin
          if (mult_start) begin
            opReg <= a;
            pHi   <= '0;
            pLo   <= b;
            qm1   <= 1'b0;
            cnt   <= '0;
          end else if (div_start) begin
`ifdef MULT_DIV_DIVIDER_EN
            div_zero <= (b == '0);
            opReg    <= absB;
            pHi      <= '0;
            pLo      <= absA;
            negQ     <= a[31] ^ b[31];
            negR     <= a[31];
            cnt      <= '0;
`else
            div_zero <= 1'b1;
`endif
          end
        end
        MULT: begin
          pHi <= boothSum[32:1];
          pLo <= {boothSum[0], pLo[31:1]};
          qm1 <= pLo[0];
          cnt <= cnt + 5'd1;
          if (lastIter) begin
            mult_hi <= boothSum[32:1];
            mult_lo <= {boothSum[0], pLo[31:1]};
          end
        end
`ifdef MULT_DIV_DIVIDER_EN
        DIV: begin
          // Keep the trial difference only when it did not borrow
          if (!divDiff[33])
            pHi <= divDiff[31:0];
          else
            pHi <= {pHi[30:0], pLo[31]};
          pLo <= {pLo[30:0], ~divDiff[33]};
          cnt <= cnt + 5'd1;
        end
        FIX: begin
          divLoR <= negQ ? -pLo : pLo;
          divHiR <= negR ? -pHi : pHi;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
// Follows MULT_DIV_DIVIDER_EN to pick the divide expectations.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mult_start, div_start;
  logic [31:0] a, b;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
  logic        div_zero, busy, done;

  int total = 0;
  int passed = 0;
  int cyc;
  int extra;

  mult_div_unit dut (
    .clk(clk), .reset(reset),
    .mult_start(mult_start), .div_start(div_start),
    .a(a), .b(b),
    .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_hi(div_hi), .div_lo(div_lo),
    .div_zero(div_zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic go(input logic m, input logic d,
                    input logic [31:0] av, input logic [31:0] bv);
    mult_start = m;
    div_start  = d;
    a = av;
    b = bv;
    step();
    mult_start = 1'b0;
    div_start  = 1'b0;
  endtask

  // Returns the cycle (edge 0 = accept) in which done is seen.
  task automatic waitDone(input int pulseAt, output int c);
    c = 1;
    while (!done && c < 200) begin
      if (c == pulseAt) div_start = 1'b1;
      step();
      div_start = 1'b0;
      c++;
    end
  endtask

  initial begin
    reset = 1'b1;
    mult_start = 1'b0;
    div_start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) step();
    chk("rst_mult_hi", mult_hi, 0);
    chk("rst_div_lo", div_lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_div_zero", div_zero, 0);
    reset = 1'b0;
    step();

    go(1, 0, 32'd7, 32'hFFFFFFFD);
    chk("m1_busy", busy, 1);
    waitDone(0, cyc);
    chk("m1_cycle", cyc, 33);
    chk("m1_hi", mult_hi, 32'hFFFFFFFF);
    chk("m1_lo", mult_lo, 32'hFFFFFFEB);
    chk("m1_div_hi", div_hi, 0);
    chk("m1_div_lo", div_lo, 0);
    step();
    chk("m1_done_pulse", done, 0);
    chk("m1_busy_fall", busy, 0);

    go(1, 0, 32'h80000000, 32'h80000000);
    waitDone(0, cyc);
    step();
    chk("m2_hi", mult_hi, 32'h40000000);
    chk("m2_lo", mult_lo, 32'h00000000);

    go(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitDone(0, cyc);
    step();
    chk("m3_hi", mult_hi, 32'h00000000);
    chk("m3_lo", mult_lo, 32'h00000001);

`ifdef MULT_DIV_DIVIDER_EN
    go(0, 1, 32'hFFFFFFF9, 32'd2);
    waitDone(0, cyc);
    chk("d1_cycle", cyc, 34);
    chk("d1_quo", div_lo, 32'hFFFFFFFD);
    chk("d1_rem", div_hi, 32'hFFFFFFFF);
    chk("d1_zero", div_zero, 0);
    chk("d1_mult_kept", mult_lo, 32'h00000001);
    step();

    go(0, 1, 32'h80000000, 32'hFFFFFFFF);
    waitDone(0, cyc);
    chk("d2_quo", div_lo, 32'h80000000);
    chk("d2_rem", div_hi, 32'h00000000);
    step();

    go(0, 1, 32'd5, 32'd0);
    chk("dz_done", done, 1);
    chk("dz_flag", div_zero, 1);
    chk("dz_quo_kept", div_lo, 32'h80000000);
    chk("dz_rem_kept", div_hi, 32'h00000000);
    step();

    go(0, 1, 32'd9, 32'd1);
    chk("dz_clear", div_zero, 0);
    waitDone(0, cyc);
    chk("d3_cycle", cyc, 34);
    chk("d3_quo", div_lo, 32'd9);
    step();
`else
    go(0, 1, 32'd5, 32'd0);
    chk("dz_done", done, 1);
    chk("dz_flag", div_zero, 1);
    chk("dz_quo", div_lo, 0);
    step();

    go(0, 1, 32'd9, 32'd1);
    chk("nd_done", done, 1);
    chk("nd_flag", div_zero, 1);
    chk("nd_quo", div_lo, 0);
    chk("nd_rem", div_hi, 0);
    step();
`endif

    go(1, 1, 32'd3, 32'd5);
    waitDone(10, cyc);
    chk("hs_cycle", cyc, 33);
    chk("hs_lo", mult_lo, 32'd15);
    chk("hs_hi", mult_hi, 32'd0);
`ifdef MULT_DIV_DIVIDER_EN
    chk("hs_div_zero", div_zero, 0);
    chk("hs_div_kept", div_lo, 32'd9);
`else
    chk("hs_div_zero", div_zero, 1);
`endif
    step();
    chk("hs_busy_fall", busy, 0);
    extra = 0;
    repeat (40) begin
      if (done) extra++;
      step();
    end
    chk("hs_no_second_done", extra, 0);

    go(1, 0, 32'h00012345, 32'h00001000);
    repeat (14) step();
    chk("rm_busy_mid", busy, 1);
    reset = 1'b1;
    step();
    chk("rm_mult_hi", mult_hi, 0);
    chk("rm_mult_lo", mult_lo, 0);
    chk("rm_div_lo", div_lo, 0);
    chk("rm_div_zero", div_zero, 0);
    chk("rm_busy", busy, 0);
    chk("rm_done", done, 0);
    reset = 1'b0;
    step();

    go(1, 0, 32'd6, 32'd7);
    waitDone(0, cyc);
    chk("rm2_cycle", cyc, 33);
    chk("rm2_lo", mult_lo, 32'd42);
    chk("rm2_hi", mult_hi, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative signed 32-bit multiply/divide unit serving the multicycle CPU's `mult`/`div` instructions. It consumes the A and B register operands and produces the HI/LO candidate values (`mult_hi`/`mult_lo`, `div_hi`/`div_lo`) plus the divide-by-zero flag. The CPU's HI/LO source muxes select among these values. The control unit uses the `start`/`done` handshake to hold the FSM in a wait state while the unit runs.

## Interface
- No parameters. The width is fixed at 32 bits and the iteration count at 32.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `mult_start` in 1: request a signed multiply of `a`×`b`. Sampled only in IDLE.
- `div_start` in 1: request a signed divide of `a`/`b`. Sampled only in IDLE.
- `a` in 32: multiplicand or dividend. Captured on the accepting edge.
- `b` in 32: multiplier or divisor. Captured on the accepting edge.
- `mult_hi` out 32: upper 32 bits of the 64-bit product.
- `mult_lo` out 32: lower 32 bits of the 64-bit product.
- `div_hi` out 32: remainder.
- `div_lo` out 32: quotient.
- `div_zero` out 1: the last accepted divide had `b == 0`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, MULT, DIV, FIX, DONE.
  - IDLE→MULT on `mult_start`.
  - IDLE→DIV on `div_start` with `b != 0`.
  - IDLE→DONE on `div_start` with `b == 0`.
  - MULT→DONE after 32 iterations.
  - DIV→FIX after 32 iterations.
  - FIX→DONE.
  - DONE→IDLE unconditionally.
- If `mult_start` and `div_start` are asserted together, the multiply wins and the divide request is dropped.
- Starts asserted outside IDLE are ignored. Operands are not re-sampled while busy.
- Multiply uses radix-2 Booth.
  - State: 64-bit product register {P_hi, P_lo = b} and a 1-bit q₋₁.
  - Each iteration adds or subtracts `a` to P_hi per {P_lo[0], q₋₁}, then arithmetic-shifts the 65-bit value right by 1.
  - The result is the exact two's-complement 64-bit product.
- Divide uses restoring division on magnitudes |a|, |b|.
  - Each iteration shifts {rem, quo} left by 1 and trial-subtracts |b|. Quotient bit = 1 when the trial result is non-negative.
  - FIX negates the quotient when sign(a) ≠ sign(b) and negates the remainder when a < 0. This gives truncation toward zero, with the remainder taking the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0, with no trap.
- Output update rules:
  - `mult_hi`/`mult_lo` load only on the MULT→DONE transition.
  - `div_hi`/`div_lo` load only on the FIX→DONE transition.
  - At all other times every result output holds its value.
- A divide by zero leaves `div_hi`/`div_lo` unchanged.
- `div_zero` is set on the edge entering DONE from a zero divide and cleared on the edge that accepts any later `div_start`.
- Reset has priority over everything. On reset, all outputs return to 0 and the state returns to IDLE, including mid-operation. Any in-flight result is discarded.

## Timing
- Let edge 0 be the edge that accepts a start.
- Multiply:
  - MULT occupies cycles 1–32 and DONE occupies cycle 33.
  - `done` = 1 during cycle 33 only.
  - Results are valid from cycle 33 onward.
- Divide with `b != 0`:
  - DIV occupies cycles 1–32, FIX cycle 33, and DONE cycle 34.
  - `done` = 1 during cycle 34.
- Divide with `b == 0`:
  - DONE occupies cycle 1, with `done` = 1 and `div_zero` = 1.
- `busy` = 1 from cycle 1 through the DONE cycle inclusive.
- The earliest next accept is the edge that ends DONE+1, i.e. the first IDLE cycle.
- `done` and `busy` are registered state decodes with no combinational path from the starts.

## Configuration
- `MULT_DIV_DIVIDER_EN` defined: the full divider is built as described above.
- `MULT_DIV_DIVIDER_EN` undefined:
  - The DIV and FIX states and the divider datapath are removed.
  - `div_start` goes IDLE→DONE in cycle 1 with `done` = 1.
  - `div_hi`/`div_lo` are tied to 0.
  - `div_zero` is set exactly as for a zero divisor, regardless of `b`, so software traps on unsupported `div`.
  - Multiply behaviour and timing are unchanged.

## Test plan
- Multiply: `a` = 7, `b` = 0xFFFFFFFD, `mult_start` at edge 0 → `done` only in cycle 33; `mult_hi` = 0xFFFFFFFF, `mult_lo` = 0xFFFFFFEB; `div_*` unchanged.
- Multiply extremes: 0x80000000 × 0x80000000 → `mult_hi` = 0x40000000, `mult_lo` = 0. Then 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000 / 0x00000001.
- Divide: `a` = 0xFFFFFFF9 (−7), `b` = 2 → `done` in cycle 34; `div_lo` = 0xFFFFFFFD, `div_hi` = 0xFFFFFFFF. Then 0x80000000 / 0xFFFFFFFF → `div_lo` = 0x80000000, `div_hi` = 0.
- Divide by zero: `a` = 5, `b` = 0 → `done` and `div_zero` = 1 in cycle 1; `div_hi`/`div_lo` keep prior values. `div_zero` clears on the next accepted `div_start` with `b` = 1.
- Handshake:
  - `mult_start` and `div_start` asserted together → multiply only, `done` at cycle 33.
  - `div_start` pulsed at cycle 10 → ignored, with no second `done`.
  - `busy` falls after cycle 33.
- Reset mid-operation: `reset` high in cycle 15 of a multiply → next cycle all outputs 0, `busy` = 0, no `done`. A fresh `mult_start` then completes normally in 33 cycles.
